uart_frame_tx: RTL

//  Parametrised multi-byte UART frame transmitter: accepts whole frames (FRAME_BYTES x DBITS) on a valid/ready

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_frame_tx_if.sv | 22 ++
 rtl/uart_frame_fifo.sv | 50 +++++
 rtl/uart_frame_tx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } state_t;

  localparam int UART_BAUD_115200_AT_100M = 868;

  function automatic int baud_w(input int clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Frame payload valid/ready handshake between application and transmitter.
interface uart_frame_tx_if #(
  parameter int W = 32
);

  logic [W-1:0] frame_in;
  logic         frame_valid;
  logic         frame_ready;

  modport master (
    output frame_in,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_in,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/uart_frame_fifo.sv
// Synchronous frame FIFO with occupancy count; full blocks pushes outright.
module uart_frame_fifo #(
  parameter int W  = 32,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  wdata,
  input  logic          push,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART frame transmitter with frame FIFO and baud generator.
// Define UART_FRAME_CKSUM_EN to append an XOR checksum character per frame.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int DBITS        = 8,
  parameter int FRAME_BYTES  = 4,
  parameter int FIFO_AW      = 2,
  parameter int CLKS_PER_BIT = UART_BAUD_115200_AT_100M,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  uart_frame_tx_if.slave    bus,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [FIFO_AW:0]  level
);

  localparam int FW = FRAME_BYTES * DBITS;
`ifdef UART_FRAME_CKSUM_EN
  localparam int NCH = FRAME_BYTES + 1;
`else
  localparam int NCH = FRAME_BYTES;
`endif
  localparam int CW   = baud_w(CLKS_PER_BIT);
  localparam int BM0  = (DBITS > STOP_BITS) ? DBITS : STOP_BITS;
  localparam int BMAX = (BM0 > GAP_BITS) ? BM0 : GAP_BITS;
  localparam int BW   = $clog2(BMAX) + 1;
  localparam int YW   = $clog2(NCH) + 1;

  localparam logic [CW-1:0] CNT_L = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DAT_L = BW'(DBITS - 1);
  localparam logic [BW-1:0] STP_L = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] GAP_L =
    BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [YW-1:0] CH_L  = YW'(NCH - 1);

  state_t            state;
  state_t            nxt;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [YW-1:0]     byte_idx;
  logic [FW-1:0]     frame_sr;
  logic [DBITS-1:0]  char_sr;
  logic [FW-1:0]     rdata;
  logic              full;
  logic              empty;
  logic              pop;
  logic              next_char;
  logic              done_c;
  logic              tick;
`ifdef UART_FRAME_CKSUM_EN
  localparam logic [YW-1:0] CK_IDX = YW'(FRAME_BYTES - 1);
  logic [DBITS-1:0]  cksum;
`endif

  uart_frame_fifo #(
    .W  (FW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk_100MHz),
    .rst   (reset),
    .wdata (bus.frame_in),
    .push  (bus.frame_valid),
    .pop   (pop),
    .rdata (rdata),
    .count (level),
    .full  (full),
    .empty (empty)
  );

  assign bus.frame_ready = !full;
  assign busy            = (state != IDLE);
  assign tick            = (cnt == CNT_L);

  always_comb begin
    nxt       = state;
    pop       = 1'b0;
    next_char = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          nxt = START;
        end
      end
      START: if (tick) nxt = DATA;
      DATA: begin
        if (tick && bit_idx == DAT_L) nxt = STOP;
      end
      STOP: begin
        if (tick && bit_idx == STP_L) begin
          if (byte_idx != CH_L) begin
            next_char = 1'b1;
            nxt       = START;
          end else begin
            done_c = 1'b1;
            // back-to-back frames skip IDLE entirely
            if (GAP_BITS > 0) begin
              nxt = GAP;
            end else if (!empty) begin
              pop = 1'b1;
              nxt = START;
            end else begin
              nxt = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (tick && bit_idx == GAP_L) begin
          if (!empty) begin
            pop = 1'b1;
            nxt = START;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      frame_sr   <= '0;
      char_sr    <= '0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
`ifdef UART_FRAME_CKSUM_EN
      cksum      <= '0;
`endif
    end else begin
      state      <= nxt;
      frame_done <= done_c;
      if (nxt != state || tick || state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (nxt != state)
        bit_idx <= '0;
      else if (tick)
        bit_idx <= bit_idx + BW'(1);
      if (pop) begin
        frame_sr <= rdata << DBITS;
        char_sr  <= rdata[FW-1 -: DBITS];
        byte_idx <= '0;
`ifdef UART_FRAME_CKSUM_EN
        cksum    <= rdata[FW-1 -: DBITS];
`endif
      end else if (next_char) begin
        byte_idx <= byte_idx + YW'(1);
`ifdef UART_FRAME_CKSUM_EN
        if (byte_idx == CK_IDX) begin
          char_sr <= cksum;
        end else begin
          char_sr  <= frame_sr[FW-1 -: DBITS];
          frame_sr <= frame_sr << DBITS;
          cksum    <= cksum ^ frame_sr[FW-1 -: DBITS];
        end
`else
        char_sr  <= frame_sr[FW-1 -: DBITS];
        frame_sr <= frame_sr << DBITS;
`endif
      end else if (state == DATA && tick) begin
        char_sr <= char_sr >> 1;
      end
      // tx trails the state by one clock so every bit is evenly registered
      tx <= (state == START) ? 1'b0 :
            (state == DATA)  ? char_sr[0] : 1'b1;
    end
  end

endmodule
